// File: rtl/trackball_pkg.sv
// rtl/trackball_pkg.sv - shared types, parameter limits and Gray-code step decoder
package trackball_pkg;

  typedef enum logic [1:0] {STEP_IDLE, STEP_UP, STEP_DOWN, STEP_ERR} quad_step_t;

  localparam int NUM_AXES_MIN    = 1;
  localparam int NUM_AXES_MAX    = 8;
  localparam int CNT_W_MIN       = 4;
  localparam int CNT_W_MAX       = 16;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 3;

  // Up order is 00->01->11->10->00; a two-bit jump is an illegal transition.
  function automatic quad_step_t quad_decode(input logic [1:0] prev, input logic [1:0] curr);
    quad_step_t step;
    case ({prev, curr})
      4'b0000, 4'b0101, 4'b1111, 4'b1010: step = STEP_IDLE;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step = STEP_UP;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step = STEP_DOWN;
      default:                            step = STEP_ERR;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/quad_axis.sv
// rtl/quad_axis.sv - one quadrature axis: synchronizer, decode, counter and flags
// Counter saturates instead of wrapping when TRACKBALL_SAT_EN is defined.
module quad_axis
  import trackball_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             i_prime,
  input  logic             i_a,
  input  logic             i_b,
  input  logic             i_flip,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_dir,
  output logic             o_step,
  output logic             o_err
);

  logic [SYNC_STAGES-1:0][1:0] r_sync;
  logic [1:0]                  r_curr;
  logic [1:0]                  r_prev;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_dir;
  logic                        r_step;
  logic                        r_err;

  quad_step_t       w_step;
  logic             w_move;
  logic             w_up;
  logic [CNT_W-1:0] w_next;

`ifdef TRACKBALL_SAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
`endif

  always_comb begin
    w_step = quad_decode(r_prev, r_curr);
    w_move = (w_step == STEP_UP) || (w_step == STEP_DOWN);
    w_up   = (w_step == STEP_UP) ^ i_flip;
`ifdef TRACKBALL_SAT_EN
    if (w_up) w_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    else      w_next = (r_cnt == CNT_MIN) ? r_cnt : r_cnt - CNT_W'(1);
`else
    w_next = w_up ? r_cnt + CNT_W'(1) : r_cnt - CNT_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_sync <= '0;
      r_curr <= '0;
      r_prev <= '0;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
      r_step <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_a, i_b};
      r_curr <= r_sync[SYNC_STAGES-1];
      // While priming, both samples load live data so the first real decode is idle.
      r_prev <= i_prime ? r_sync[SYNC_STAGES-1] : r_curr;
      r_step <= 1'b0;
      if (i_clr) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (!i_prime) begin
        if (w_move) begin
          r_cnt  <= w_next;
          r_dir  <= w_up;
          r_step <= 1'b1;
        end else if (w_step == STEP_ERR) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_dir  = r_dir;
  assign o_step = r_step;
  assign o_err  = r_err;

endmodule

// File: rtl/trackball_multi.sv
// rtl/trackball_multi.sv - multi-axis quadrature trackball decoder with shared priming
// Define TRACKBALL_SAT_EN to make the position counters saturate rather than wrap.
module trackball_multi
  import trackball_pkg::*;
#(
  parameter int NUM_AXES    = 2,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic [NUM_AXES-1:0]       quad_a,
  input  logic [NUM_AXES-1:0]       quad_b,
  input  logic                      flip,
  input  logic [NUM_AXES-1:0]       clr,
  output logic [NUM_AXES*CNT_W-1:0] cnt_o,
  output logic [NUM_AXES-1:0]       dir_o,
  output logic [NUM_AXES-1:0]       step_o,
  output logic [NUM_AXES-1:0]       err_o
);

  localparam int PRIME_CYC = SYNC_STAGES + 1;

  if (NUM_AXES < NUM_AXES_MIN || NUM_AXES > NUM_AXES_MAX ||
      CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX ||
      SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_cfg
    $error("trackball_multi: parameter out of range");
  end

  logic [2:0] r_prime_cnt;
  logic       w_prime;

  assign w_prime = (r_prime_cnt != 3'(PRIME_CYC));

  always_ff @(posedge clk) begin
    if (!rst_l)       r_prime_cnt <= '0;
    else if (w_prime) r_prime_cnt <= r_prime_cnt + 3'd1;
  end

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    quad_axis #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_axis (
      .clk     (clk),
      .rst_l   (rst_l),
      .i_prime (w_prime),
      .i_a     (quad_a[i]),
      .i_b     (quad_b[i]),
      .i_flip  (flip),
      .i_clr   (clr[i]),
      .o_cnt   (cnt_o[i*CNT_W +: CNT_W]),
      .o_dir   (dir_o[i]),
      .o_step  (step_o[i]),
      .o_err   (err_o[i])
    );
  end

endmodule
